freelist: RTL

- Physical-register free list for the R10K-style rename path. It sits beside dispatch.
- Each cycle it presents the next free physical tags to dispatch and pops the ones dispatch consumes.
- It receives freed T_old tags from ROB retire.
- On branch flush it restores its allocation pointer to the architectural (retire) point.

---
 rtl/freelist_if.sv | 65 ++++++
 rtl/freelist.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/freelist_if.sv
// freelist_if: dispatch/retire bundle for the physical-register free list.
// The err flag exists only when FREELIST_ERR_EN is defined.
interface freelist_if #(
  parameter int WAYS     = 2,
  parameter int PR_BITS  = 6,
  parameter int CNT_BITS = 6
);
  logic [WAYS-1:0]         new_pr_en;
  logic                    branch_flush_en;
  logic [WAYS-1:0]         retire_en;
  logic [WAYS-1:0]         retire_has_dest;
  logic [WAYS*PR_BITS-1:0] retire_told_idx;
  logic [WAYS*PR_BITS-1:0] t_idx;
  logic [CNT_BITS-1:0]     free_count;
  logic [WAYS-1:0]         stall;
`ifdef FREELIST_ERR_EN
  logic                    err;

  modport master (
    output new_pr_en,
    output branch_flush_en,
    output retire_en,
    output retire_has_dest,
    output retire_told_idx,
    input  t_idx,
    input  free_count,
    input  stall,
    input  err
  );

  modport slave (
    input  new_pr_en,
    input  branch_flush_en,
    input  retire_en,
    input  retire_has_dest,
    input  retire_told_idx,
    output t_idx,
    output free_count,
    output stall,
    output err
  );
`else
  modport master (
    output new_pr_en,
    output branch_flush_en,
    output retire_en,
    output retire_has_dest,
    output retire_told_idx,
    input  t_idx,
    input  free_count,
    input  stall
  );

  modport slave (
    input  new_pr_en,
    input  branch_flush_en,
    input  retire_en,
    input  retire_has_dest,
    input  retire_told_idx,
    output t_idx,
    output free_count,
    output stall
  );
`endif
endinterface

// File: rtl/freelist.sv
// freelist: R10K-style physical-register free list with flush restore.
// Define FREELIST_ERR_EN for a sticky overflow/underflow err flag.
module freelist #(
  parameter int WAYS       = 2,
  parameter int N_PHYS_REG = 64,
  parameter int N_ARCH_REG = 32
) (
  input logic       clock,
  input logic       reset,
  freelist_if.slave bus
);
  localparam int DEPTH    = N_PHYS_REG - N_ARCH_REG;
  localparam int PR_BITS  = $clog2(N_PHYS_REG);
  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW       = IDX_BITS + 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  localparam logic [NW-1:0] DEPTH_S = NW'(DEPTH);

  typedef logic [NW-1:0]       ptr_t;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [PR_BITS-1:0]  tag_t;

  function automatic idx_t idx_add(idx_t i, logic [NW-1:0] n);
    logic [NW-1:0] s;
    s = {1'b0, i} + n;
    if (s >= DEPTH_S) s = s - DEPTH_S;
    return s[IDX_BITS-1:0];
  endfunction

  // Pointer = {wrap, idx}; wrap toggles on each lap so full != empty.
  function automatic ptr_t ptr_add(ptr_t p, logic [NW-1:0] n);
    logic [NW-1:0] s;
    logic          w;
    s = {1'b0, p[IDX_BITS-1:0]} + n;
    w = p[IDX_BITS];
    if (s >= DEPTH_S) begin
      s = s - DEPTH_S;
      w = ~w;
    end
    return {w, s[IDX_BITS-1:0]};
  endfunction

  tag_t          mem_q [DEPTH];
  ptr_t          head_q, head_d;
  ptr_t          arch_q, arch_d;
  ptr_t          tail_q, tail_d;
  logic [NW-1:0] cnt_w;
  logic [NW-1:0] n_alloc, n_ret, n_push;
  logic [WAYS-1:0] stall_w, alloc_v, push_v;
  idx_t          wr_idx [WAYS];
  tag_t          told_w [WAYS];
`ifdef FREELIST_ERR_EN
  logic          err_q, err_d;
  logic [NW-1:0] avail;
`endif

  always_comb begin
    cnt_w = {1'b0, tail_q[IDX_BITS-1:0]}
          - {1'b0, head_q[IDX_BITS-1:0]};
    if (tail_q[IDX_BITS] != head_q[IDX_BITS])
      cnt_w = cnt_w + DEPTH_S;
    for (int i = 0; i < WAYS; i++)
      stall_w[i] = NW'(i + 1) > cnt_w;
  end

  always_comb begin
    bus.t_idx = '0;
    for (int k = 0; k < WAYS; k++)
      bus.t_idx[k*PR_BITS +: PR_BITS] =
        mem_q[idx_add(head_q[IDX_BITS-1:0], NW'(k))];
  end

  assign bus.free_count = CNT_BITS'(cnt_w);
  assign bus.stall      = stall_w;

  always_comb begin
    alloc_v = bus.new_pr_en & ~stall_w;
    n_alloc = '0;
    n_ret   = '0;
    n_push  = '0;
    push_v  = '0;
`ifdef FREELIST_ERR_EN
    err_d = err_q;
    if (!bus.branch_flush_en && (bus.new_pr_en & stall_w) != '0)
      err_d = 1'b1;
`endif
    for (int i = 0; i < WAYS; i++) begin
      n_alloc = n_alloc + NW'(alloc_v[i]);
      n_ret   = n_ret + NW'(bus.retire_en[i] & bus.retire_has_dest[i]);
    end
`ifdef FREELIST_ERR_EN
    avail = cnt_w - n_alloc;
`endif
    // Pushes compact in way order; tag 0 is never returned to the list.
    for (int i = 0; i < WAYS; i++) begin
      told_w[i] = bus.retire_told_idx[i*PR_BITS +: PR_BITS];
      wr_idx[i] = idx_add(tail_q[IDX_BITS-1:0], n_push);
      if (bus.retire_en[i] && bus.retire_has_dest[i] && told_w[i] != '0) begin
`ifdef FREELIST_ERR_EN
        if (avail + n_push >= DEPTH_S) begin
          err_d = 1'b1;
        end else begin
          push_v[i] = 1'b1;
          n_push    = n_push + 1'b1;
        end
`else
        push_v[i] = 1'b1;
        n_push    = n_push + 1'b1;
`endif
      end
    end
    tail_d = ptr_add(tail_q, n_push);
    arch_d = ptr_add(arch_q, n_ret);
    head_d = bus.branch_flush_en ? arch_d : ptr_add(head_q, n_alloc);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      arch_q <= '0;
      tail_q <= {1'b1, {IDX_BITS{1'b0}}};
      for (int k = 0; k < DEPTH; k++)
        mem_q[k] <= PR_BITS'(N_ARCH_REG + k);
`ifdef FREELIST_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      head_q <= head_d;
      arch_q <= arch_d;
      tail_q <= tail_d;
      for (int i = 0; i < WAYS; i++)
        if (push_v[i]) mem_q[wr_idx[i]] <= told_w[i];
`ifdef FREELIST_ERR_EN
      err_q <= err_d;
`endif
    end
  end

`ifdef FREELIST_ERR_EN
  assign bus.err = err_q;
`endif

endmodule
